// File: rtl/frame_analyzer.sv
// rtl/frame_analyzer.sv - per-frame lit-pixel statistics from a sync/rgb video stream
// Raster position is rebuilt from registered syncs; one result per frame leaves on a valid/ready port.
module frame_analyzer #(
  parameter int SYNC_ACTIVE_HIGH = 1,
  parameter int H_ACTIVE         = 640,
  parameter int H_BACK           = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_BACK           = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [18:0] res_count,
  output logic [9:0]  res_xmin,
  output logic [9:0]  res_xmax,
  output logic [9:0]  res_ymin,
  output logic [9:0]  res_ymax,
  output logic        res_empty,
  output logic [9:0]  res_lines,
  output logic        res_err,
  output logic        overrun
);

  typedef enum logic [1:0] {S_UNLOCKED, S_RUN, S_HALT} state_t;

  localparam logic        SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);
  localparam logic        SYNC_OFF = ~SYNC_ON;
  localparam logic [10:0] H_LO     = 11'(H_BACK);
  localparam logic [10:0] H_HI     = 11'(H_BACK + H_ACTIVE);
  localparam logic [10:0] V_LO     = 11'(V_BACK);
  localparam logic [10:0] V_HI     = 11'(V_BACK + V_ACTIVE);

  logic       r_hs_q, r_vs_q, r_hs_d, r_vs_d;
  logic [2:0] r_rgb_q;
  logic [9:0] r_hcount, r_vcount, w_hcount, w_vcount;
  logic       w_h_deassert, w_v_deassert, w_v_assert, w_hsat;
  logic       w_pix_lit, w_acc, w_publish;
  logic [9:0] w_x, w_y;
  state_t     r_state, w_state_nxt;

  logic [18:0] r_count;
  logic [9:0]  r_xmin, r_xmax, r_ymin, r_ymax, r_lines;
  logic        r_empty, r_err;

  assign w_h_deassert = (r_hs_q == SYNC_OFF) && (r_hs_d == SYNC_ON);
  assign w_v_deassert = (r_vs_q == SYNC_OFF) && (r_vs_d == SYNC_ON);
  assign w_v_assert   = (r_vs_q == SYNC_ON)  && (r_vs_d == SYNC_OFF);

  // Counters are resolved combinationally so an event cycle itself already sees hcount/vcount 0.
  always_comb begin
    w_hsat   = 1'b0;
    w_hcount = r_hcount + 10'd1;
    if (w_h_deassert) begin
      w_hcount = '0;
    end else if (r_hcount == 10'h3FF) begin
      w_hcount = r_hcount;
      w_hsat   = 1'b1;
    end
    w_vcount = r_vcount;
    if (w_v_deassert) begin
      w_vcount = '0;
    end else if (w_h_deassert && (r_vcount != 10'h3FF)) begin
      w_vcount = r_vcount + 10'd1;
    end
  end

  assign w_x = w_hcount - H_LO[9:0];
  assign w_y = w_vcount - V_LO[9:0];
  assign w_pix_lit = (r_hs_q == SYNC_OFF) && (r_vs_q == SYNC_OFF) && (r_rgb_q != 3'd0) &&
                     ({1'b0, w_hcount} >= H_LO) && ({1'b0, w_hcount} < H_HI) &&
                     ({1'b0, w_vcount} >= V_LO) && ({1'b0, w_vcount} < V_HI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hs_q   <= SYNC_OFF;
      r_vs_q   <= SYNC_OFF;
      r_hs_d   <= SYNC_OFF;
      r_vs_d   <= SYNC_OFF;
      r_rgb_q  <= '0;
      r_hcount <= '0;
      r_vcount <= '0;
      r_state  <= S_UNLOCKED;
    end else begin
      r_hs_q   <= hsync;
      r_vs_q   <= vsync;
      r_hs_d   <= r_hs_q;
      r_vs_d   <= r_vs_q;
      r_rgb_q  <= rgb;
      r_hcount <= w_hcount;
      r_vcount <= w_vcount;
      r_state  <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    case (r_state)
      S_UNLOCKED: if (w_v_deassert) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_v_assert) begin
          w_state_nxt = S_HALT;
          w_publish   = 1'b1;
        end
      end
      S_HALT:     if (w_v_deassert) w_state_nxt = S_RUN;
      default:    w_state_nxt = S_UNLOCKED;
    endcase
  end

  assign w_acc = (r_state == S_RUN) && !w_v_deassert;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymin  <= '0;
      r_ymax  <= '0;
      r_lines <= '0;
      r_empty <= 1'b1;
      r_err   <= 1'b0;
    end else if (w_v_deassert) begin
      r_count <= '0;
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymin  <= '0;
      r_ymax  <= '0;
      r_lines <= '0;
      r_empty <= 1'b1;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      if (w_hsat) r_err <= 1'b1;
      if (w_h_deassert && (r_lines != 10'h3FF)) r_lines <= r_lines + 10'd1;
      if (w_pix_lit) begin
        if (r_count != 19'h7FFFF) r_count <= r_count + 19'd1;
        r_empty <= 1'b0;
        if (r_empty || (w_x < r_xmin)) r_xmin <= w_x;
        if (r_empty || (w_x > r_xmax)) r_xmax <= w_x;
        if (r_empty || (w_y < r_ymin)) r_ymin <= w_y;
        if (r_empty || (w_y > r_ymax)) r_ymax <= w_y;
      end
    end
  end

  // A result arriving while the previous one is still unaccepted is dropped, not queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_count <= '0;
      res_xmin  <= '0;
      res_xmax  <= '0;
      res_ymin  <= '0;
      res_ymax  <= '0;
      res_empty <= 1'b0;
      res_lines <= '0;
      res_err   <= 1'b0;
      overrun   <= 1'b0;
    end else if (w_publish && (!res_valid || res_ready)) begin
      res_valid <= 1'b1;
      res_count <= r_count;
      res_xmin  <= r_xmin;
      res_xmax  <= r_xmax;
      res_ymin  <= r_ymin;
      res_ymax  <= r_ymax;
      res_empty <= r_empty;
      res_lines <= r_lines;
      res_err   <= r_err;
    end else begin
      if (w_publish) overrun <= 1'b1;
      if (res_valid && res_ready) res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_analyzer.sv
// tb/tb_frame_analyzer.sv - randomized and directed bench for frame_analyzer
// A raw-sample reference model predicts every frame result from the sync/pixel stream.
module tb_frame_analyzer;

  localparam int HA   = 40;
  localparam int HB   = 6;
  localparam int VA   = 20;
  localparam int VB   = 3;
  localparam int HSW  = 4;
  localparam int HTOT = HSW + HB + HA + 6;
  localparam int VSW  = 2;
  localparam int VIN  = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync, vsync, res_ready;
  logic [2:0]  rgb;
  logic        res_valid, res_empty, res_err, overrun;
  logic [18:0] res_count;
  logic [9:0]  res_xmin, res_xmax, res_ymin, res_ymax, res_lines;

  always #5 clk = ~clk;

  frame_analyzer #(
    .SYNC_ACTIVE_HIGH(1), .H_ACTIVE(HA), .H_BACK(HB), .V_ACTIVE(VA), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
    .res_xmin(res_xmin), .res_xmax(res_xmax), .res_ymin(res_ymin), .res_ymax(res_ymax),
    .res_empty(res_empty), .res_lines(res_lines), .res_err(res_err), .overrun(overrun)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_xfer   = 0;
  int          n_vhi    = 0;
  int          base;
  bit          mon_en, g_ready;
  logic [70:0] last;
  logic [70:0] q[$];
  int          rx0, rx1, ry0, ry1;

  bit m_hs, m_vs, m_on, m_empty, m_err;
  int m_k, m_v, m_count, m_xmin, m_xmax, m_ymin, m_ymax, m_lines;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [70:0] dut_vec();
    return {res_count, res_xmin, res_xmax, res_ymin, res_ymax, res_empty, res_lines, res_err};
  endfunction

  function automatic logic [70:0] mvec();
    return {19'(m_count), 10'(m_xmin), 10'(m_xmax), 10'(m_ymin), 10'(m_ymax),
            m_empty, 10'(m_lines), m_err};
  endfunction

  task automatic model_reset();
    m_hs = 0; m_vs = 0; m_on = 0; m_empty = 1; m_err = 0;
    m_k = 0; m_v = 0; m_count = 0; m_lines = 0;
    m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
    q.delete();
  endtask

  task automatic model(input logic hs, input logic vs, input logic [2:0] c);
    bit hd, vd, va;
    int x, y;
    hd = m_hs && !hs;
    vd = m_vs && !vs;
    va = !m_vs && vs;
    m_hs = hs;
    m_vs = vs;
    if (hd) m_k = 0;
    else if (m_k == 1023) m_err = m_err | m_on;
    else m_k++;
    if (vd) m_v = 0;
    else if (hd && m_v < 1023) m_v++;
    x = m_k - HB;
    y = m_v - VB;
    if (vd) begin
      m_count = 0; m_lines = 0; m_empty = 1; m_err = 0; m_on = 1;
      m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
    end else if (va) begin
      if (m_on) q.push_back(mvec());
      m_on = 0;
    end else if (m_on) begin
      if (hd && m_lines < 1023) m_lines++;
      if (!hs && !vs && x >= 0 && x < HA && y >= 0 && y < VA && c != 0) begin
        if (m_empty) begin
          m_xmin = x; m_xmax = x; m_ymin = y; m_ymax = y;
        end else begin
          if (x < m_xmin) m_xmin = x;
          if (x > m_xmax) m_xmax = x;
          if (y < m_ymin) m_ymin = y;
          if (y > m_ymax) m_ymax = y;
        end
        m_count++;
        m_empty = 0;
      end
    end
  endtask

  task automatic step(input logic hs, input logic vs, input logic [2:0] c, input logic rdy);
    @(negedge clk);
    hsync = hs; vsync = vs; rgb = c; res_ready = rdy;
    if (res_valid) n_vhi++;
    if (res_valid && res_ready) begin
      n_xfer++;
      last = dut_vec();
      if (mon_en) begin
        check("result_expected", 80'(q.size() != 0), 80'(1));
        if (q.size() != 0) check("frame_result", last, q.pop_front());
      end
    end
    model(hs, vs, c);
  endtask

  function automatic logic [2:0] pix(input int mode, input int h, input int x, input int y);
    case (mode)
      0: return (x >= rx0 && x <= rx1 && y >= ry0 && y <= ry1) ? 3'($urandom_range(1, 7)) : 3'd0;
      2: return ((x == 0 && y == 0) || (x == HA-1 && y == VA-1) || (x == -1 && y == 0) ||
                 (x == HA && y == 3) || (x == 5 && y == -1) || (x == 5 && y == VA) ||
                 (h == 1 && y == 5)) ? 3'd4 : 3'd0;
      3: return ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  // Frame = VIN lines with vsync inactive, then VSW lines of vsync; the result publishes in the tail.
  task automatic run_frame(input int mode, input int stall, input int stop, input bit pulse);
    for (int l = 0; l < VIN + VSW; l++) begin
      int hlen;
      if (l == stop) return;
      hlen = (l == stall) ? HSW + 1100 : HTOT;
      for (int h = 0; h < hlen; h++)
        step(h < HSW, l >= VIN, pix(mode, h, h - HSW - HB, l + 1 - VB),
             g_ready | (pulse && l == VIN && h == 1));
    end
  endtask

  initial begin
    reset = 1'b0; hsync = 1'b0; vsync = 1'b0; rgb = 3'd0; res_ready = 1'b0;
    g_ready = 1; mon_en = 1; last = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", 80'(res_valid), 80'(0));
    check("rst_overrun", 80'(overrun), 80'(0));
    check("rst_res", 80'(dut_vec()), 80'(0));
    reset = 1'b1;
    for (int i = 0; i < VSW * HTOT; i++) step((i % HTOT) < HSW, 1'b1, 3'd0, 1'b1);

    rx0 = 10; rx1 = 19; ry0 = 5; ry1 = 9; base = n_xfer;
    run_frame(0, -1, -1, 0);
    check("rect_xfer", 80'(n_xfer - base), 80'(1));
    check("rect_result", 80'(last), 80'({19'd50, 10'd10, 10'd19, 10'd5, 10'd9, 1'b0, 10'd24, 1'b0}));

    base = n_xfer; n_vhi = 0;
    run_frame(1, -1, -1, 0);
    check("black_xfer", 80'(n_xfer - base), 80'(1));
    check("black_valid_cycles", 80'(n_vhi), 80'(1));
    check("black_result", 80'(last), 80'({19'd0, 40'd0, 1'b1, 10'd24, 1'b0}));

    run_frame(2, -1, -1, 0);
    check("corner_result", 80'(last), 80'({19'd2, 10'd0, 10'd39, 10'd0, 10'd19, 1'b0, 10'd24, 1'b0}));

    run_frame(1, 5, -1, 0);
    check("stall_result", 80'(last), 80'({19'd0, 40'd0, 1'b1, 10'd24, 1'b1}));
    run_frame(1, -1, -1, 0);
    check("clean_after_stall", 80'(last), 80'({19'd0, 40'd0, 1'b1, 10'd24, 1'b0}));

    repeat (5) run_frame(3, -1, -1, 0);
    check("queue_drained", 80'(q.size()), 80'(0));

    mon_en = 0; g_ready = 0;
    rx0 = 2; rx1 = 4; ry0 = 1; ry1 = 2;
    run_frame(0, -1, -1, 0);
    rx0 = 0; rx1 = 9; ry0 = 0; ry1 = 0;
    run_frame(0, -1, -1, 0);
    check("ovr_valid_held", 80'(res_valid), 80'(1));
    check("ovr_flag", 80'(overrun), 80'(1));
    check("ovr_first_held", 80'(dut_vec()), 80'({19'd6, 10'd2, 10'd4, 10'd1, 10'd2, 1'b0, 10'd24, 1'b0}));
    rx0 = 30; rx1 = 39; ry0 = 10; ry1 = 19;
    run_frame(0, -1, -1, 1);
    check("ovr_xfer_first", 80'(last), 80'({19'd6, 10'd2, 10'd4, 10'd1, 10'd2, 1'b0, 10'd24, 1'b0}));
    check("ovr_third_valid", 80'(res_valid), 80'(1));
    check("ovr_third_loaded", 80'(dut_vec()), 80'({19'd100, 10'd30, 10'd39, 10'd10, 10'd19, 1'b0, 10'd24, 1'b0}));
    g_ready = 1;
    repeat (4) step(1'b0, 1'b1, 3'd0, 1'b1);
    check("ovr_drained", 80'(res_valid), 80'(0));
    check("ovr_sticky", 80'(overrun), 80'(1));
    q.delete(); mon_en = 1;

    rx0 = 10; rx1 = 19; ry0 = 5; ry1 = 9;
    run_frame(0, -1, 5, 0);
    #3 reset = 1'b0;
    #1;
    check("arst_overrun", 80'(overrun), 80'(0));
    check("arst_valid", 80'(res_valid), 80'(0));
    check("arst_res", 80'(dut_vec()), 80'(0));
    hsync = 1'b0; vsync = 1'b0; rgb = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    base = n_xfer;
    run_frame(0, -1, -1, 0);
    check("post_rst_no_result", 80'(n_xfer - base), 80'(0));
    check("post_rst_valid_low", 80'(res_valid), 80'(0));
    run_frame(0, -1, -1, 0);
    check("post_rst_one_result", 80'(n_xfer - base), 80'(1));
    check("post_rst_result", 80'(last), 80'({19'd50, 10'd10, 10'd19, 10'd5, 10'd9, 1'b0, 10'd24, 1'b0}));
    check("final_queue", 80'(q.size()), 80'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_analyzer.md
FRAME_ANALYZER -- requirements
Module: frame_analyzer

Interface
REQ-001 Parameter SYNC_ACTIVE_HIGH, default 1: level at which hsync/vsync are asserted.
REQ-002 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-003 Parameter H_BACK, default 48: clocks from hsync deassertion to first active pixel.
REQ-004 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-005 Parameter V_BACK, default 33: lines from vsync deassertion to first active line.
REQ-006 Port clk, input, 1: pixel clock, rising-edge; all other inputs synchronous to it.
REQ-007 Port reset, input, 1: one clock; reset is asynchronous and active-low.
REQ-008 Port hsync, input, 1: horizontal sync of the video stream under analysis.
REQ-009 Port vsync, input, 1: vertical sync of the video stream under analysis.
REQ-010 Port rgb, input, 3: pixel colour; nonzero means lit.
REQ-011 Port res_valid, output, 1: a frame result is held on the res_* outputs.
REQ-012 Port res_ready, input, 1: consumer accepts the result.
REQ-013 Port res_count, output, 19: lit active pixels in the frame.
REQ-014 Port res_xmin/res_xmax/res_ymin/res_ymax, output, 10 each: lit-pixel bounding box, inclusive.
REQ-015 Port res_empty, output, 1: frame had no lit active pixel.
REQ-016 Port res_lines, output, 10: hsync deassertions counted in the frame.
REQ-017 Port res_err, output, 1: a line exceeded 1023 clocks in the frame.
REQ-018 Port overrun, output, 1: sticky; a completed frame was dropped.

Function
REQ-019 hsync, vsync, rgb SHALL be registered once (hs_q, vs_q, rgb_q); all decisions use registered values, plus one further delay for edge detection.
REQ-020 H-deassert event: hs_q inactive and previous hs_q active; V-deassert and V-assert events defined likewise on vs_q.
REQ-021 hcount (10 bit) SHALL be 0 on an H-deassert cycle, else increment, saturating at 1023; saturation sets the frame error flag.
REQ-022 vcount (10 bit) SHALL clear on V-deassert, else increment on H-deassert, saturating at 1023; V-deassert wins when coincident with H-deassert.
REQ-023 Pixel active iff hs_q and vs_q inactive, H_BACK <= hcount < H_BACK+H_ACTIVE, V_BACK <= vcount < V_BACK+V_ACTIVE; x = hcount-H_BACK, y = vcount-V_BACK.
REQ-024 Active pixel with rgb_q != 0 SHALL increment the count and update min/max x/y; the first lit pixel of a frame loads all four bounds.
REQ-025 States: UNLOCKED (after reset, no accumulation), RUN (entered on first V-deassert; accumulating).
REQ-026 On V-deassert in RUN or UNLOCKED: clear count, bounds, empty flag (set to 1), line count, error flag.
REQ-027 On V-assert in RUN: frame result = accumulators (empty frame: bounds 0, res_empty 1); published per REQ-028..030; then accumulation halts until next V-deassert.
REQ-028 Publish when res_valid=0, or res_valid=1 and res_ready=1 same cycle: load res_*, res_valid=1 next cycle.
REQ-029 Publish attempt with res_valid=1 and res_ready=0: new result dropped, held result unchanged, overrun set next cycle.
REQ-030 res_valid & res_ready without publish: res_valid clears next cycle; res_* hold while res_valid=1 and not transferred.
REQ-031 res_count SHALL saturate at 2^19-1; not reachable with defaults.
REQ-032 V-assert in UNLOCKED SHALL publish nothing.

Reset
REQ-033 While reset low: state UNLOCKED, res_valid 0, overrun 0, all res_* 0, counters 0, sync history registers at inactive level.
REQ-034 Reset deassertion mid-frame: no result until after the next full V-deassert..V-assert interval.

Verification
REQ-035 Standard 800x525 timing, filled rect x100..199, y50..59, res_ready=1 -> count 1000, xmin 100, xmax 199, ymin 50, ymax 59, empty 0, lines 525 minus vsync-width lines, err 0.
REQ-036 All-black frame -> count 0, empty 1, bounds 0, res_valid pulses one cycle with res_ready=1.
REQ-037 res_ready=0 for two frames -> first result held unchanged, overrun=1; res_ready=1 with third V-assert -> third result loaded, res_valid stays 1.
REQ-038 Single lit pixel at x=0,y=0 and x=639,y=479 -> count 2, bounds 0/639/0/479; pixel lit during hcount=H_BACK-1 or blanking -> not counted.
REQ-039 hsync held inactive 1100 clocks within a frame -> res_err 1 in that frame's result, 0 in the next clean frame.
REQ-040 reset pulsed low mid-frame -> outputs zero asynchronously; first res_valid only after the second subsequent V-assert.
